// File: rtl/object_motion_ctrl_pkg.sv
// Shared types and constants for the object motion controller.
// GRAVITY and VY_MAX are used only when OBJECT_MOTION_GRAVITY_EN is defined.
package fruit_motion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    // Vertical acceleration per tick, toward the bottom of the screen
    localparam int unsigned GRAVITY = 1;
    // Ceiling on the downward speed reached under gravity
    localparam int unsigned VY_MAX  = 255;

    // Bit positions inside wall_hit = {top, bottom, left, right}
    localparam int unsigned WH_TOP    = 3;
    localparam int unsigned WH_BOTTOM = 2;
    localparam int unsigned WH_LEFT   = 1;
    localparam int unsigned WH_RIGHT  = 0;

endpackage

// File: rtl/object_motion_ctrl_if.sv
// Velocity update handshake between a motion source and object_motion_ctrl.
interface object_motion_ctrl_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic [X_W-1:0] vx;
    logic           dx;
    logic [Y_W-1:0] vy;
    logic           dy;
    logic           vel_valid;
    logic           vel_ready;

    modport master (output vx, dx, vy, dy, vel_valid, input vel_ready);
    modport slave  (input vx, dx, vy, dy, vel_valid, output vel_ready);
endinterface

// File: rtl/object_motion_ctrl_axis.sv
// One-axis position step: pos +/- v, then clamp or reflect against [0, lim].
// lim = SCREEN - size, or 0 when the object is at least as large as the screen.
module motion_axis #(
    parameter int W      = 10,
    parameter int SCREEN = 640
) (
    input  logic [W-1:0] pos,
    input  logic [W-1:0] v,
    input  logic         dir,      // 1 = toward 0
    input  logic [W-1:0] size,
    input  logic         bounce,
    output logic [W-1:0] lim,
    output logic [W-1:0] nxt,
    output logic         hit_lo,
    output logic         hit_hi
);
    // One bit beyond W+2 so that the 2*lim - sum reflection cannot wrap
    typedef logic signed [W+2:0] wide_t;

    localparam wide_t SCR = wide_t'(SCREEN);

    wide_t size_w;
    wide_t lim_w;
    wide_t sum;
    wide_t res;

    // Limit, raw step, wall detection and clamp/reflect with final saturation
    always_comb begin
        size_w = wide_t'({3'b000, size});
        if (size_w >= SCR) begin
            lim_w = '0;
        end else begin
            lim_w = SCR - size_w;
        end

        if (dir) begin
            sum = wide_t'({3'b000, pos}) - wide_t'({3'b000, v});
        end else begin
            sum = wide_t'({3'b000, pos}) + wide_t'({3'b000, v});
        end

        hit_lo = 1'b0;
        hit_hi = 1'b0;
        res    = sum;
        if (sum < 0) begin
            hit_lo = 1'b1;
            res    = bounce ? -sum : '0;
        end else if (sum > lim_w) begin
            hit_hi = 1'b1;
            res    = bounce ? (lim_w + lim_w - sum) : lim_w;
        end

        if (res < 0) begin
            res = '0;
        end else if (res > lim_w) begin
            res = lim_w;
        end

        nxt = res[W-1:0];
        lim = lim_w[W-1:0];
    end

endmodule

// File: rtl/object_motion_ctrl.sv
// Object motion controller: moves a rectangle across the playfield on each
// synchronised moveclk rising edge, clamping or bouncing at the walls.
// Optional feature macro: OBJECT_MOTION_GRAVITY_EN (vertical acceleration).
module object_motion_ctrl
    import fruit_motion_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 moveclk,
    input  logic                 load,
    input  logic                 freeze,
    input  logic                 bounce,
    object_motion_ctrl_if.slave  vel,
    input  logic [X_W-1:0]       width,
    input  logic [Y_W-1:0]       height,
    input  logic [X_W-1:0]       initposx,
    input  logic [Y_W-1:0]       initposy,
    output logic [X_W-1:0]       posx,
    output logic [Y_W-1:0]       posy,
    output logic                 active,
    output logic [3:0]           wall_hit
);

    state_t state, state_nxt;

    logic mc_s1, mc_s2, mc_s3;
    logic tick;
    logic move;
    logic ready;
    logic accept;

    logic [X_W-1:0] vx_q;
    logic           dx_q;
    logic [Y_W-1:0] vy_q;
    logic           dy_q;

    logic [X_W-1:0] xlim, xnxt;
    logic [Y_W-1:0] ylim, ynxt;
    logic           xhit_lo, xhit_hi, yhit_lo, yhit_hi;
    logic           dx_after, dy_after;
    logic [Y_W-1:0] vy_step;
    logic           dy_step;

    // Two-flop synchroniser plus one delay flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_s1 <= 1'b0;
            mc_s2 <= 1'b0;
            mc_s3 <= 1'b0;
        end else begin
            mc_s1 <= moveclk;
            mc_s2 <= mc_s1;
            mc_s3 <= mc_s2;
        end
    end

    assign tick = mc_s2 & ~mc_s3;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; load takes priority over everything else
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = ST_RUN;
        end else begin
            unique case (state)
                ST_IDLE:   state_nxt = ST_IDLE;
                ST_RUN:    state_nxt = freeze ? ST_FROZEN : ST_RUN;
                ST_FROZEN: state_nxt = freeze ? ST_FROZEN : ST_RUN;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // State-derived outputs and the per-tick move enable
    always_comb begin
        active = (state == ST_RUN) || (state == ST_FROZEN);
        ready  = active;
        move   = tick && (state == ST_RUN) && !freeze;
    end

    assign vel.vel_ready = ready;
    assign accept        = vel.vel_valid & ready;

    motion_axis #(.W(X_W), .SCREEN(SCREEN_W)) u_axis_x (
        .pos    (posx),
        .v      (vx_q),
        .dir    (dx_q),
        .size   (width),
        .bounce (bounce),
        .lim    (xlim),
        .nxt    (xnxt),
        .hit_lo (xhit_lo),
        .hit_hi (xhit_hi)
    );

    motion_axis #(.W(Y_W), .SCREEN(SCREEN_H)) u_axis_y (
        .pos    (posy),
        .v      (vy_q),
        .dir    (dy_q),
        .size   (height),
        .bounce (bounce),
        .lim    (ylim),
        .nxt    (ynxt),
        .hit_lo (yhit_lo),
        .hit_hi (yhit_hi)
    );

    assign dx_after = dx_q ^ (bounce & (xhit_lo | xhit_hi));
    assign dy_after = dy_q ^ (bounce & (yhit_lo | yhit_hi));

`ifdef OBJECT_MOTION_GRAVITY_EN
    localparam int unsigned VY_FULL = (32'd1 << Y_W) - 32'd1;
    localparam int unsigned VY_CAP  = (VY_MAX > VY_FULL) ? VY_FULL : VY_MAX;

    // Gravity applied after any bounce reversal: slow down going up, speed up going down
    always_comb begin
        vy_step = vy_q;
        dy_step = dy_after;
        if (dy_after) begin
            if (32'(vy_q) > GRAVITY) begin
                vy_step = Y_W'(32'(vy_q) - GRAVITY);
                dy_step = 1'b1;
            end else begin
                vy_step = '0;
                dy_step = 1'b0;
            end
        end else begin
            if (32'(vy_q) + GRAVITY >= VY_CAP) begin
                vy_step = Y_W'(VY_CAP);
            end else begin
                vy_step = Y_W'(32'(vy_q) + GRAVITY);
            end
            dy_step = 1'b0;
        end
    end
`else
    // Vertical speed stays constant between accepted updates
    always_comb begin
        vy_step = vy_q;
        dy_step = dy_after;
    end
`endif

    // Velocity registers: an accepted update overrides any same-cycle reversal
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vx_q <= '0;
            dx_q <= 1'b0;
            vy_q <= '0;
            dy_q <= 1'b0;
        end else if (accept) begin
            vx_q <= vel.vx;
            dx_q <= (vel.vx != '0) ? vel.dx : 1'b0;
            vy_q <= vel.vy;
            dy_q <= (vel.vy != '0) ? vel.dy : 1'b0;
        end else if (move) begin
            dx_q <= dx_after;
            vy_q <= vy_step;
            dy_q <= dy_step;
        end
    end

    // Position registers: load (clamped to the limit) wins over a tick step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            posx <= '0;
            posy <= '0;
        end else if (load) begin
            posx <= (initposx > xlim) ? xlim : initposx;
            posy <= (initposy > ylim) ? ylim : initposy;
        end else if (move) begin
            posx <= xnxt;
            posy <= ynxt;
        end
    end

    // One-cycle wall pulses, only for steps that actually moved the object
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wall_hit <= '0;
        end else begin
            wall_hit <= '0;
            if (move && !load) begin
                wall_hit[WH_TOP]    <= yhit_lo;
                wall_hit[WH_BOTTOM] <= yhit_hi;
                wall_hit[WH_LEFT]   <= xhit_lo;
                wall_hit[WH_RIGHT]  <= xhit_hi;
            end
        end
    end

endmodule

// File: tb/tb_object_motion_ctrl.sv
// Directed bench for object_motion_ctrl with hand-computed expectations.
// Gravity-specific vectors are included when OBJECT_MOTION_GRAVITY_EN is defined.
module tb_object_motion_ctrl;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    logic           clk = 1'b0;
    logic           rst;
    logic           moveclk;
    logic           load;
    logic           freeze;
    logic           bounce;
    logic [X_W-1:0] width;
    logic [Y_W-1:0] height;
    logic [X_W-1:0] initposx;
    logic [Y_W-1:0] initposy;
    logic [X_W-1:0] posx;
    logic [Y_W-1:0] posy;
    logic           active;
    logic [3:0]     wall_hit;

    logic [3:0]     hit_snap;
    logic [3:0]     hit_after;
    logic [3:0]     hit_or;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    object_motion_ctrl_if #(.X_W(X_W), .Y_W(Y_W)) vif ();

    object_motion_ctrl #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .SCREEN_W (640),
        .SCREEN_H (480)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .moveclk  (moveclk),
        .load     (load),
        .freeze   (freeze),
        .bounce   (bounce),
        .vel      (vif.slave),
        .width    (width),
        .height   (height),
        .initposx (initposx),
        .initposy (initposy),
        .posx     (posx),
        .posy     (posy),
        .active   (active),
        .wall_hit (wall_hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        @(negedge clk);
        initposx = x;
        initposy = y;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic set_vel(input logic [X_W-1:0] vx, input logic dx,
                           input logic [Y_W-1:0] vy, input logic dy);
        @(negedge clk);
        vif.vx        = vx;
        vif.dx        = dx;
        vif.vy        = vy;
        vif.dy        = dy;
        vif.vel_valid = 1'b1;
        @(negedge clk);
        vif.vel_valid = 1'b0;
    endtask

    // One moveclk pulse; hit_snap is wall_hit right after the update edge,
    // hit_after is wall_hit one cycle later
    task automatic tick();
        @(negedge clk);
        moveclk = 1'b1;
        repeat (3) @(posedge clk);
        #1 hit_snap = wall_hit;
        @(posedge clk);
        #1 hit_after = wall_hit;
        @(negedge clk);
        moveclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Tick with a velocity update presented in the same cycle as the update edge
    task automatic tick_with_vel(input logic [X_W-1:0] vx, input logic dx,
                                 input logic [Y_W-1:0] vy, input logic dy);
        @(negedge clk);
        moveclk = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vif.vx        = vx;
        vif.dx        = dx;
        vif.vy        = vy;
        vif.dy        = dy;
        vif.vel_valid = 1'b1;
        @(posedge clk);
        #1 hit_snap = wall_hit;
        vif.vel_valid = 1'b0;
        @(negedge clk);
        moveclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        moveclk       = 1'b0;
        load          = 1'b0;
        freeze        = 1'b0;
        bounce        = 1'b0;
        width         = 10'd20;
        height        = 9'd20;
        initposx      = '0;
        initposy      = '0;
        vif.vx        = '0;
        vif.dx        = 1'b0;
        vif.vy        = '0;
        vif.dy        = 1'b0;
        vif.vel_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_posx", posx, 0);
        check("rst_posy", posy, 0);
        check("rst_active", active, 0);
        check("rst_ready", vif.vel_ready, 0);
        check("rst_wall_hit", wall_hit, 0);
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores ticks
        tick();
        check("idle_posx", posx, 0);

        // Basic motion: (100,50), vx=3 right, vy=2 down, 4 ticks
        do_load(10'd100, 9'd50);
        check("load_active", active, 1);
        check("load_posx", posx, 100);
        check("load_posy", posy, 50);
        set_vel(10'd3, 1'b0, 9'd2, 1'b0);
        hit_or = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            hit_or = hit_or | hit_snap | hit_after;
        end
        check("run4_posx", posx, 112);
`ifdef OBJECT_MOTION_GRAVITY_EN
        check("run4_posy", posy, 64);
`else
        check("run4_posy", posy, 58);
`endif
        check("run4_wall_hit", hit_or, 0);

        // Clamp at the right wall: width 40 -> xmax 600
        width = 10'd40;
        do_load(10'd598, 9'd50);
        set_vel(10'd5, 1'b0, 9'd0, 1'b0);
        tick();
        check("clamp_posx", posx, 600);
        check("clamp_hit", hit_snap, 4'b0001);
        check("clamp_hit_1cyc", hit_after, 4'b0000);
        tick();
        check("clamp_dir_kept_posx", posx, 600);
        check("clamp_dir_kept_hit", hit_snap, 4'b0001);

        // Bounce off the left wall: 2 - 5 = -3 -> 3, direction becomes right
        bounce = 1'b1;
        do_load(10'd2, 9'd50);
        set_vel(10'd5, 1'b1, 9'd0, 1'b0);
        tick();
        check("bounce_posx", posx, 3);
        check("bounce_hit", hit_snap, 4'b0010);
        tick();
        check("bounce_dir_right", posx, 8);
        check("bounce_no_hit", hit_snap, 4'b0000);

        // Freeze holds position; movement resumes after release
        bounce = 1'b0;
        width  = 10'd20;
        do_load(10'd100, 9'd100);
        set_vel(10'd1, 1'b0, 9'd0, 1'b0);
        @(negedge clk);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frozen_posx", posx, 100);
        end
        check("frozen_active", active, 1);
        check("frozen_ready", vif.vel_ready, 1);
        @(negedge clk);
        freeze = 1'b0;
        tick();
        check("unfreeze_posx", posx, 101);

        // Load above the limit clamps to the limit
        width  = 10'd40;
        height = 9'd20;
        do_load(10'd700, 9'd470);
        check("loadclamp_posx", posx, 600);
        check("loadclamp_posy", posy, 460);
        width  = 10'd640;
        height = 9'd480;
        do_load(10'd5, 9'd7);
        check("fullsize_posx", posx, 0);
        check("fullsize_posy", posy, 0);

        // Top wall clamp: 1 - 3 -> 0
        width  = 10'd20;
        height = 9'd20;
        do_load(10'd100, 9'd1);
        set_vel(10'd0, 1'b0, 9'd3, 1'b1);
        tick();
        check("top_clamp_posy", posy, 0);
        check("top_clamp_hit", hit_snap, 4'b1000);

        // Bottom wall bounce: 458 + 5 = 463 -> 2*460 - 463 = 457
        bounce = 1'b1;
        do_load(10'd100, 9'd458);
        set_vel(10'd0, 1'b0, 9'd5, 1'b0);
        tick();
        check("bottom_bounce_posy", posy, 457);
        check("bottom_bounce_hit", hit_snap, 4'b0100);

        // Velocity accepted on the tick cycle applies from the next tick
        bounce = 1'b0;
        do_load(10'd100, 9'd100);
        set_vel(10'd2, 1'b0, 9'd0, 1'b0);
        tick_with_vel(10'd10, 1'b0, 9'd0, 1'b0);
        check("samecyc_old_vel", posx, 102);
        tick();
        check("samecyc_new_vel", posx, 112);

        // Wall hit plus velocity update: new velocity wins, no reversal
        bounce = 1'b1;
        do_load(10'd2, 9'd100);
        set_vel(10'd5, 1'b1, 9'd0, 1'b0);
        tick_with_vel(10'd1, 1'b1, 9'd0, 1'b0);
        check("hitvel_posx", posx, 3);
        check("hitvel_hit", hit_snap, 4'b0010);
        tick();
        check("hitvel_dir_new", posx, 2);

        // Reset between the moveclk edge and the update
        bounce = 1'b0;
        width  = 10'd40;
        do_load(10'd598, 9'd100);
        set_vel(10'd5, 1'b0, 9'd0, 1'b0);
        @(negedge clk);
        moveclk = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_posx", posx, 0);
        check("midrst_posy", posy, 0);
        check("midrst_active", active, 0);
        @(negedge clk);
        rst = 1'b0;
        hit_or = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 hit_or = hit_or | wall_hit;
        end
        @(negedge clk);
        moveclk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 hit_or = hit_or | wall_hit;
        end
        check("midrst_no_hit", hit_or, 0);
        check("midrst_posx_after", posx, 0);
        check("midrst_idle", active, 0);

`ifdef OBJECT_MOTION_GRAVITY_EN
        // Gravity: vy=2 up -> moves -2, -1, 0, +1, +2 from 100
        begin
            int exp_y [5] = '{98, 97, 97, 98, 100};
            width  = 10'd20;
            height = 9'd20;
            do_load(10'd100, 9'd100);
            set_vel(10'd0, 1'b0, 9'd2, 1'b1);
            for (int i = 0; i < 5; i++) begin
                tick();
                check("gravity_posy", posy, exp_y[i]);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/object_motion_ctrl.md
OBJECT_MOTION_CTRL -- requirements
Module: object_motion_ctrl

Interface
REQ-001 Parameter X_W, default 10: horizontal position/velocity width.
REQ-002 Parameter Y_W, default 9: vertical position/velocity width.
REQ-003 Parameter SCREEN_W, default 640: playfield width in pixels.
REQ-004 Parameter SCREEN_H, default 480: playfield height in pixels.
REQ-005 clk  in  1  system clock; the single clock of the block.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 moveclk  in  1  slow motion tick, asynchronous square wave.
REQ-008 load  in  1  one-cycle strobe; loads initposx/initposy and enters RUN.
REQ-009 freeze  in  1  level; holds position while high.
REQ-010 bounce  in  1  level; 1 = reflect at walls, 0 = clamp at walls.
REQ-011 vx / dx  in  X_W / 1  horizontal speed magnitude and direction (1 = left).
REQ-012 vy / dy  in  Y_W / 1  vertical speed magnitude and direction (1 = up).
REQ-013 vel_valid  in  1  velocity update request; accepted when vel_ready is high.
REQ-014 vel_ready  out  1  high in RUN and FROZEN.
REQ-015 width / height  in  X_W / Y_W  object size.
REQ-016 initposx / initposy  in  X_W / Y_W  load position.
REQ-017 posx / posy  out  X_W / Y_W  current top-left position, registered.
REQ-018 active  out  1  high in RUN or FROZEN.
REQ-019 wall_hit  out  4  one-cycle pulses {top, bottom, left, right}.

Function
REQ-020 moveclk passes through a 2-flop synchroniser; its rising edge generates a one-cycle tick; latency from moveclk edge to position update is 3 clk cycles.
REQ-021 States: IDLE, RUN, FROZEN; IDLE->RUN on load; RUN->FROZEN while freeze; FROZEN->RUN on freeze low; any state->RUN on load; load wins over freeze.
REQ-022 The velocity registers (magnitude and direction) latch vx/dx/vy/dy when vel_valid and vel_ready are both high; a zero magnitude forces the stored direction to 0.
REQ-023 On a tick in RUN: new = pos +/- v, computed at X_W+2 / Y_W+2 bits signed; no update in IDLE or FROZEN.
REQ-024 Limits: xmax = SCREEN_W-width and ymax = SCREEN_H-height; when the size is at least the screen size, the limit is 0.
REQ-025 Clamp mode: result<0 -> 0 and result>max -> max; the direction is unchanged; the matching wall_hit bit pulses.
REQ-026 Bounce mode: result<0 -> -result and result>max -> 2*max-result, each saturated into [0, max]; the stored direction toggles; the matching wall_hit bit pulses.
REQ-027 A vel_valid accepted in the same cycle as a tick takes effect from the next tick; the current tick uses the old velocity.
REQ-028 A wall hit and an accepted velocity update in the same cycle: the new velocity wins, and no direction toggle is applied.
REQ-029 load with an init position above max: the position is clamped to max on load.

Reset
REQ-030 rst high: state IDLE, posx=0, posy=0, velocities 0, directions 0, wall_hit=0, active=0, synchroniser flops 0.
REQ-031 Reset mid-motion: the pending tick is discarded, and no wall_hit pulse is emitted on release.

Configuration
REQ-032 Macro OBJECT_MOTION_GRAVITY_EN: when defined, each RUN tick also applies vertical acceleration GRAVITY (package constant, default 1) toward the bottom: the upward speed decrements; on reaching 0 the direction flips to down; the downward speed increments, saturating at VY_MAX.
REQ-033 Without OBJECT_MOTION_GRAVITY_EN: the vertical speed is constant between accepted updates; the GRAVITY logic is absent.

Structure
REQ-034 Package fruit_motion_pkg SHALL hold the state enum, GRAVITY, VY_MAX, and the wall_hit bit indices.
REQ-035 One sub-module, motion_axis, parametrised by width, SHALL implement the REQ-023..026 step for one axis; it SHALL be instantiated twice.

Verification
REQ-036 load with init (100,50), vx=3 right, vy=2 down, 4 ticks -> pos (112,58); wall_hit stays 0.
REQ-037 Clamp mode, width=40, posx=598, vx=5 right, 1 tick -> posx=600, left-bit... right wall_hit pulses for 1 cycle, dx unchanged.
REQ-038 Bounce mode, posx=2, vx=5 left, 1 tick -> posx=3, dx becomes right, left wall_hit pulses.
REQ-039 freeze high across 3 ticks -> position constant; after freeze low, the next tick moves the object.
REQ-040 Gravity enabled, vy=2 up, 5 ticks -> vertical speeds 1 up, 0->down, 1 down, 2 down, 3 down; posy matches the running sum.
REQ-041 rst asserted between a moveclk edge and the update -> pos=0, IDLE, no wall_hit after release.
